// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: default widths
// and the bit positions of the per-instruction control payload.
package pipe_pkg;

  localparam int unsigned CTRL_W_DEFAULT = 6;
  localparam int unsigned EXMEM_DATA_W   = 72;
  localparam int unsigned CNT_W_DEFAULT  = 16;

  localparam int unsigned CTRL_BRANCH   = 0;
  localparam int unsigned CTRL_MEMREAD  = 1;
  localparam int unsigned CTRL_MEMTOREG = 2;
  localparam int unsigned CTRL_MEMWRITE = 3;
  localparam int unsigned CTRL_REGWRITE = 4;
  localparam int unsigned CTRL_BRTAKEN  = 5;

  // Occupancy of the two-entry register, used to pick the update rule.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_MAIN  = 2'b01,
    OCC_FULL  = 2'b11
  } occ_e;

  function automatic occ_e occ_of(input logic m_valid, input logic s_valid);
    if (s_valid)      return OCC_FULL;
    else if (m_valid) return OCC_MAIN;
    else              return OCC_EMPTY;
  endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous active-high clear; sticks at all-ones.
module pipe_sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Parametrised pipeline stage register with valid/ready handshake and a
// two-entry skid buffer. Define PIPE_PERF_CNT_EN to build the stall/flush counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = EXMEM_DATA_W,
  parameter int unsigned CTRL_W = CTRL_W_DEFAULT,
  parameter int unsigned CNT_W  = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              m_valid, s_valid, in_ready_q;
  logic [DATA_W-1:0] m_data, s_data;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl;

  logic              m_valid_n, s_valid_n, in_ready_n;
  logic [DATA_W-1:0] m_data_n, s_data_n;
  logic [CTRL_W-1:0] m_ctrl_n, s_ctrl_n;

  logic accept, main_free;
  occ_e occ;

  assign accept    = in_valid & in_ready_q;
  assign main_free = ~m_valid | out_ready;
  assign occ       = occ_of(m_valid, s_valid);

  always_comb begin
    m_valid_n = m_valid;
    m_data_n  = m_data;
    m_ctrl_n  = m_ctrl;
    s_valid_n = s_valid;
    s_data_n  = s_data;
    s_ctrl_n  = s_ctrl;

    if (flush) begin
      m_valid_n = 1'b0;
      m_data_n  = '0;
      m_ctrl_n  = '0;
      s_valid_n = 1'b0;
      s_data_n  = '0;
      s_ctrl_n  = '0;
    end else if (main_free) begin
      if (occ == OCC_FULL) begin
        // in_ready is low whenever the skid is full, so no input competes here.
        m_valid_n = 1'b1;
        m_data_n  = s_data;
        m_ctrl_n  = s_ctrl;
        s_valid_n = 1'b0;
      end else if (accept) begin
        m_valid_n = 1'b1;
        m_data_n  = in_data;
        m_ctrl_n  = in_ctrl;
      end else begin
        m_valid_n = 1'b0;
      end
    end else if (accept) begin
      s_valid_n = 1'b1;
      s_data_n  = in_data;
      s_ctrl_n  = in_ctrl;
    end

    in_ready_n = ~s_valid_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_ctrl     <= '0;
      s_valid    <= 1'b0;
      s_data     <= '0;
      s_ctrl     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      m_valid    <= m_valid_n;
      m_data     <= m_data_n;
      m_ctrl     <= m_ctrl_n;
      s_valid    <= s_valid_n;
      s_data     <= s_data_n;
      s_ctrl     <= s_ctrl_n;
      in_ready_q <= in_ready_n;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign out_ctrl  = m_valid ? m_ctrl : '0;

`ifdef PIPE_PERF_CNT_EN
  logic stall_inc, flush_inc;

  assign stall_inc = m_valid & ~out_ready;
  assign flush_inc = flush & (m_valid | s_valid);

  pipe_sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .cnt (stall_cnt)
  );

  pipe_sat_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc),
    .cnt (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid; counter checks follow
// PIPE_PERF_CNT_EN.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int unsigned DW = 72;
  localparam int unsigned CW = 6;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [15:0]   stall_cnt, flush_cnt;
  logic          in_ready2, out_valid2;
  logic [DW-1:0] out_data2;
  logic [CW-1:0] out_ctrl2;
  logic [1:0]    stall_cnt2, flush_cnt2;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [CW-1:0] regw;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_ctrl(out_ctrl2),
    .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_ctrl  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_ctrl !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b d=%h c=%b want v=0 d=0 c=0", out_valid, out_data, out_ctrl);
    end
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_streaming();
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      in_ctrl  = CW'(i);
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL stream_ready_%0d: got %b want 1", i, in_ready);
      end
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== DW'(i) || out_ctrl !== CW'(i)) begin
        miscompares++;
        $display("FAIL stream_word_%0d: got v=%b d=%h c=%b want v=1 d=%h c=%b",
                 i, out_valid, out_data, out_ctrl, DW'(i), CW'(i));
      end
    end
    idle_inputs();
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_drain: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 72'h11; in_ctrl = 6'd1;
    tick();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 72'h11) begin
      miscompares++;
      $display("FAIL bp_first: got rdy=%b v=%b d=%h want 1 1 11", in_ready, out_valid, out_data);
    end
    in_data = 72'h22; in_ctrl = 6'd2;
    tick();
    vectors++;
    if (in_ready !== 1'b0 || out_data !== 72'h11) begin
      miscompares++;
      $display("FAIL bp_full: got rdy=%b d=%h want 0 11", in_ready, out_data);
    end
    in_data = 72'h33; in_ctrl = 6'd3;
    tick();
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 72'h11 || out_ctrl !== 6'd1) begin
      miscompares++;
      $display("FAIL bp_hold: got rdy=%b v=%b d=%h c=%b want 0 1 11 000001",
               in_ready, out_valid, out_data, out_ctrl);
    end
    idle_inputs();
    out_ready = 1'b1;
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 72'h22 || out_ctrl !== 6'd2 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: got v=%b d=%h c=%b rdy=%b want 1 22 000010 1",
               out_valid, out_data, out_ctrl, in_ready);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_no_extra: got out_valid=%b d=%h want 0", out_valid, out_data);
    end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = regw;
    in_data = 72'hA1;
    tick();
    in_data = 72'hA2;
    tick();
    vectors++;
    if (in_ready !== 1'b0 || out_ctrl !== regw) begin
      miscompares++;
      $display("FAIL flush_prefill: got rdy=%b c=%b want 0 %b", in_ready, out_ctrl, regw);
    end
    flush = 1'b1; in_data = 72'hEE;
    tick();
    idle_inputs();
    vectors++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_full: got v=%b c=%b d=%h rdy=%b want 0 0 0 1",
               out_valid, out_ctrl, out_data, in_ready);
    end
    out_ready = 1'b1;
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_skid_gone: got v=%b d=%h want 0", out_valid, out_data);
    end
    // Main-only occupancy: the word offered under flush sees in_ready=1 yet is dropped.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 72'hB1; in_ctrl = regw;
    tick();
    flush = 1'b1; in_data = 72'hEF;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_handshake: got in_ready=%b want 1", in_ready);
    end
    tick();
    idle_inputs();
    out_ready = 1'b1;
    vectors++;
    if (out_valid !== 1'b0 || out_ctrl !== '0) begin
      miscompares++;
      $display("FAIL flush_drop_v: got v=%b c=%b want 0 0", out_valid, out_ctrl);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_drop_late: got v=%b d=%h want 0", out_valid, out_data);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = regw;
    in_data = 72'hC1;
    tick();
    in_data = 72'hC2;
    tick();
    idle_inputs();
    rst = 1'b1;
    tick();
    vectors++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_ctrl !== '0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_stall_during: got v=%b d=%h c=%b rdy=%b want 0 0 0 0",
               out_valid, out_data, out_ctrl, in_ready);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_stall_after: got rdy=%b v=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_bubble();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b0; in_ctrl = '1; in_data = 72'h5;
    tick();
    tick();
    vectors++;
    if (out_valid !== 1'b0 || out_ctrl !== '0) begin
      miscompares++;
      $display("FAIL bubble_idle: got v=%b c=%b want 0 0", out_valid, out_ctrl);
    end
    in_valid = 1'b1;
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_ctrl !== 6'b111111) begin
      miscompares++;
      $display("FAIL bubble_word: got v=%b c=%b want 1 111111", out_valid, out_ctrl);
    end
    in_valid = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b0 || out_ctrl !== '0) begin
      miscompares++;
      $display("FAIL bubble_after: got v=%b c=%b want 0 0", out_valid, out_ctrl);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  pat;
    int unsigned nxt_in, exp;
    logic        took, acc;
    logic [DW-1:0] obs;
    do_reset();
    pat = 8'b1001_1010;
    nxt_in = 1;
    exp = 1;
    for (int c = 0; c < 40; c++) begin
      out_ready = (c < 30) ? pat[c % 8] : 1'b1;
      in_valid  = (nxt_in <= 12);
      in_data   = DW'(nxt_in);
      in_ctrl   = CW'(nxt_in);
      took = out_valid & out_ready;
      acc  = in_valid & in_ready;
      obs  = out_data;
      tick();
      if (took) begin
        vectors++;
        if (obs !== DW'(exp)) begin
          miscompares++;
          $display("FAIL order_word_%0d: got %h want %h", exp, obs, DW'(exp));
        end
        exp++;
      end
      if (acc) nxt_in++;
    end
    idle_inputs();
    vectors++;
    if (exp != 13) begin
      miscompares++;
      $display("FAIL order_count: got %0d words want 12", exp - 1);
    end
  endtask

  task automatic test_perf();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 72'hD1; in_ctrl = regw;
    tick();
    idle_inputs();
    for (int i = 0; i < 5; i++) tick();
`ifdef PIPE_PERF_CNT_EN
    vectors++;
    if (stall_cnt !== 16'd5) begin
      miscompares++;
      $display("FAIL perf_stall5: got %0d want 5", stall_cnt);
    end
`else
    vectors++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL perf_tied: got stall=%0d flush=%0d want 0 0", stall_cnt, flush_cnt);
    end
`endif
    for (int i = 0; i < 5; i++) tick();
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    tick();
`ifdef PIPE_PERF_CNT_EN
    vectors++;
    if (stall_cnt !== 16'd10 || flush_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL perf_counts: got stall=%0d flush=%0d want 10 1", stall_cnt, flush_cnt);
    end
    vectors++;
    if (stall_cnt2 !== 2'd3) begin
      miscompares++;
      $display("FAIL perf_saturate: got %0d want 3", stall_cnt2);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vectors++;
    if (flush_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL perf_empty_flush: got %0d want 1", flush_cnt);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (stall_cnt !== '0 || flush_cnt !== '0 || stall_cnt2 !== '0) begin
      miscompares++;
      $display("FAIL perf_clear: got stall=%0d flush=%0d stall2=%0d want 0", stall_cnt, flush_cnt, stall_cnt2);
    end
`else
    vectors++;
    if (stall_cnt2 !== 2'd0 || flush_cnt2 !== 2'd0 || flush_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL perf_tied2: got stall2=%0d flush2=%0d flush=%0d want 0", stall_cnt2, flush_cnt2, flush_cnt);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    regw = '0;
    regw[CTRL_REGWRITE] = 1'b1;
    rst = 1'b1;
    out_ready = 1'b0;
    idle_inputs();
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_reset_mid_stall();
    test_bubble();
    test_back_to_back();
    test_perf();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised inter-stage pipeline register, successor to the fixed EX/MEM latch; usable for IF/ID, ID/EX, EX/MEM and MEM/WB.
- Splits each stage word into a data field and a control field.
- Adds a valid/ready handshake with a 2-entry skid buffer, so stalls from a downstream stage do not need a combinational ready path.
- Flush inserts a bubble: valid and all control bits are cleared, so no regwrite/memwrite leaks from a squashed instruction.

Parameters:
- DATA_W, 72, width of the datapath payload (e.g. pc_branch 32 + alu 32 + rd 5 + misc).
- CTRL_W, 6, width of the control payload (branch, memread, memtoreg, memwrite, regwrite, branch_taken).
- CNT_W, 16, width of the perf counters (optional feature only).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  squash every held entry this cycle.
- in_valid  in  1  upstream offers a word.
- in_ready  out  1  stage can accept a word; driven from a register only.
- in_data  in  DATA_W  upstream datapath payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- out_valid  out  1  output word is valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  DATA_W  datapath payload to the next stage.
- out_ctrl  out  CTRL_W  control payload; forced to 0 whenever out_valid=0.
- stall_cnt  out  CNT_W  cycles with out_valid & !out_ready (PIPE_PERF_CNT_EN only).
- flush_cnt  out  CNT_W  flushes that killed at least one valid entry (PIPE_PERF_CNT_EN only).

Behaviour:
- State:
  - main entry: m_valid, m_data, m_ctrl. Drives the outputs.
  - skid entry: s_valid, s_data, s_ctrl.
- Reset:
  - All valids, data and ctrl go to 0.
  - in_ready=0 while rst is high; in_ready=1 in the first cycle after rst drops.
  - out_valid=0, out_data=0, out_ctrl=0.
  - Counters go to 0.
- Handshake definitions:
  - in_ready = !s_valid, as a register.
  - An input is accepted when in_valid & in_ready.
  - An output is taken when out_valid & out_ready.
  - out_valid = m_valid; out_data = m_data; out_ctrl = m_valid ? m_ctrl : 0.
- Latency and throughput: 1 cycle from acceptance to out_valid; sustained throughput of 1 word/cycle when out_ready=1.
- Update rules (no flush, no rst), evaluated in priority order:
  - Main empty or taken, skid full: main <= skid; skid empties. A simultaneous accept is impossible because in_ready=0.
  - Main empty or taken, skid empty: main <= input if accepted, otherwise main goes invalid.
  - Main held (valid & !out_ready) and input accepted: skid <= input. in_ready falls the next cycle.
  - Main held, no accept: hold.
- Ordering: words are strictly in order and none is duplicated or dropped; the skid entry never overtakes the main entry.
- Flush (priority over everything except rst):
  - m_valid, s_valid, m_ctrl, s_ctrl and both data fields go to 0.
  - An input offered in the same cycle is discarded. in_ready reads 1 in that cycle (the upstream sees a handshake) but the word is dropped.
  - in_ready=1 the next cycle.
- rst and flush together: rst behaviour.
- rst mid-stall: all contents are lost; no partial state survives.
- Backpressure with out_ready=0 forever: at most 2 words are held, then in_ready=0.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - flush_cnt increments on flush when m_valid | s_valid.
  - Both saturate at all-ones and clear on rst.
- Undefined: stall_cnt and flush_cnt are tied to 0 and no counter flops are synthesised.

Decomposition:
- Shared package pipe_pkg: CTRL_W default, control-bit index constants (CTRL_BRANCH=0, CTRL_MEMREAD=1, CTRL_MEMTOREG=2, CTRL_MEMWRITE=3, CTRL_REGWRITE=4, CTRL_BRTAKEN=5), EXMEM_DATA_W=72.
- One natural sub-module, pipe_sat_cnt: a saturating counter instantiated twice under the macro.

Test Plan:
- Streaming: rst, then in_valid=1 with in_data=1,2,3,… and out_ready=1 → out_data=1,2,3,… one cycle later, no gaps, in_ready stays 1.
- Backpressure: send A=0x11, B=0x22 with out_ready=0 → in_ready=0 after B; out_data=0x11 held. Raise out_ready → 0x11 then 0x22 on consecutive cycles; in_ready returns to 1.
- Flush: both entries full with ctrl=6'b010000 (regwrite), pulse flush → next cycle out_valid=0, out_ctrl=0, in_ready=1. A word offered during the flush cycle never appears.
- Reset mid-stall: both entries full, assert rst for 1 cycle → out_valid=0, out_data=0, in_ready=0 during rst, then 1 after.
- Bubble gating: in_valid=0 with in_ctrl=6'b111111 → out_ctrl remains 0.
- PIPE_PERF_CNT_EN: hold out_ready=0 for 5 cycles with main valid, then flush → stall_cnt=5, flush_cnt=1. With CNT_W=2, 10 stall cycles → stall_cnt=3.
